// File: rtl/addr_seq_arbiter_pkg.sv
// Shared types and constants for the buffer address sequencer/arbiter.
// Holds the FSM state encoding, requester count, default sizes and the timer width helper.
package addr_seq_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_REQ       = 2;
  localparam int DEF_ADDR_W    = 3;
  localparam int DEF_NUM_WORDS = 4;
  localparam int DEF_PERIOD    = 2;

  // Wide enough to hold PERIOD-1, with one spare bit so PERIOD=1 still gets a 1-bit timer
  function automatic int timer_w(input int period);
    return $clog2(period) + 1;
  endfunction

endpackage

// File: rtl/addr_seq_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick: the pointer's requester wins if it asks,
// otherwise the other one does. The pointer register itself lives in the parent.
module rr_arbiter2
  import addr_seq_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  always_comb begin
    o_gnt = '0;
    if (i_req[i_ptr]) begin
      o_gnt[i_ptr] = 1'b1;
    end else if (i_req[~i_ptr]) begin
      o_gnt[~i_ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/addr_seq_arbiter.sv
// Grants one of two requesters, then walks addresses 0..NUM_WORDS-1 with one oe_o strobe
// every PERIOD cycles (stretched by hold_i), and pulses done_o to the served requester.
module addr_seq_arbiter
  import addr_seq_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int PERIOD    = DEF_PERIOD
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [NUM_REQ-1:0]  req_i,
  input  logic                hold_i,
  output logic [NUM_REQ-1:0]  gnt_o,
  output logic [ADDR_W-1:0]   add_o,
  output logic                oe_o,
  output logic                last_o,
  output logic [NUM_REQ-1:0]  done_o,
  output logic                busy_o
);

  localparam int TW = timer_w(PERIOD);

  if (NUM_WORDS < 1 || NUM_WORDS > (1 << ADDR_W)) begin : g_bad_num_words
    $error("addr_seq_arbiter: NUM_WORDS must be in 1 .. 2**ADDR_W");
  end
  if (PERIOD < 1) begin : g_bad_period
    $error("addr_seq_arbiter: PERIOD must be >= 1");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic [TW-1:0]       r_timer;
  logic [TW-1:0]       w_timer_nxt;
  logic                r_ptr;
  logic                w_ptr_nxt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [ADDR_W-1:0]   r_add;
  logic [ADDR_W-1:0]   w_add_nxt;
  logic                r_oe;
  logic                w_oe_nxt;
  logic                r_last;
  logic                w_last_nxt;
  logic [NUM_REQ-1:0]  r_done;
  logic [NUM_REQ-1:0]  w_done_nxt;
  logic                r_busy;
  logic                w_busy_nxt;

  logic [NUM_REQ-1:0]  w_win;
  logic                w_due;
  logic [ADDR_W-1:0]   w_add_inc;
  logic                w_add_is_last;

  rr_arbiter2 u_rr (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_win)
  );

  // The address register doubles as the word counter; it never exceeds NUM_WORDS-1
  assign w_due         = (r_timer == TW'(PERIOD - 1));
  assign w_add_inc     = r_add + ADDR_W'(1);
  assign w_add_is_last = (w_add_inc == ADDR_W'(NUM_WORDS - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (|req_i) w_state_nxt = ST_RUN;
      ST_RUN:  if (r_last) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt_nxt   = r_gnt;
    w_add_nxt   = r_add;
    w_timer_nxt = r_timer;
    w_ptr_nxt   = r_ptr;
    w_oe_nxt    = 1'b0;
    w_last_nxt  = 1'b0;
    w_done_nxt  = '0;
    unique case (r_state)
      ST_IDLE: begin
        w_gnt_nxt   = w_win;
        w_add_nxt   = '0;
        w_timer_nxt = '0;
        if (|req_i) begin
          w_oe_nxt   = 1'b1;
          w_last_nxt = (NUM_WORDS == 1);
        end
      end
      ST_RUN: begin
        if (r_last) begin
          // Hand the pointer to whoever was not just served
          w_done_nxt  = r_gnt;
          w_gnt_nxt   = '0;
          w_add_nxt   = '0;
          w_timer_nxt = '0;
          w_ptr_nxt   = r_gnt[0];
        end else if (w_due) begin
          if (!hold_i) begin
            w_add_nxt   = w_add_inc;
            w_oe_nxt    = 1'b1;
            w_last_nxt  = w_add_is_last;
            w_timer_nxt = '0;
          end
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      ST_DONE: begin
        w_gnt_nxt   = '0;
        w_add_nxt   = '0;
        w_timer_nxt = '0;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_add_nxt   = '0;
        w_timer_nxt = '0;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_timer <= '0;
      r_ptr   <= 1'b0;
      r_gnt   <= '0;
      r_add   <= '0;
      r_oe    <= 1'b0;
      r_last  <= 1'b0;
      r_done  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_timer <= w_timer_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_add   <= w_add_nxt;
      r_oe    <= w_oe_nxt;
      r_last  <= w_last_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  assign gnt_o  = r_gnt;
  assign add_o  = r_add;
  assign oe_o   = r_oe;
  assign last_o = r_last;
  assign done_o = r_done;
  assign busy_o = r_busy;

  a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RST_N) $onehot0(gnt_o));
  a_oe_has_gnt: assert property (@(posedge CLK) disable iff (!RST_N) oe_o |-> (gnt_o != '0));

endmodule

// File: tb/tb_addr_seq_arbiter.sv
// Randomized bench for addr_seq_arbiter: a transaction-level model predicts strobe/done events
// into a queue, and a negedge monitor pops and compares them as the DUT produces them.
module tb_addr_seq_arbiter;

  localparam int AW  = 3;
  localparam int NW  = 4;
  localparam int PER = 2;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic [1:0] req_i = 2'b00;
  logic       hold_i = 1'b0;
  logic [1:0] gnt_o;
  logic [AW-1:0] add_o;
  logic       oe_o;
  logic       last_o;
  logic [1:0] done_o;
  logic       busy_o;

  logic [1:0] req2 = 2'b00;
  logic       hold2 = 1'b0;
  logic [1:0] gnt2;
  logic [2:0] add2;
  logic       oe2;
  logic       last2;
  logic [1:0] done2;
  logic       busy2;

  addr_seq_arbiter #(.ADDR_W(AW), .NUM_WORDS(NW), .PERIOD(PER)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .req_i(req_i), .hold_i(hold_i),
    .gnt_o(gnt_o), .add_o(add_o), .oe_o(oe_o), .last_o(last_o),
    .done_o(done_o), .busy_o(busy_o)
  );

  addr_seq_arbiter #(.ADDR_W(3), .NUM_WORDS(8), .PERIOD(1)) u_dut8 (
    .CLK(CLK), .RST_N(RST_N), .req_i(req2), .hold_i(hold2),
    .gnt_o(gnt2), .add_o(add2), .oe_o(oe2), .last_o(last2),
    .done_o(done2), .busy_o(busy2)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    bit         is_done;
    logic [1:0] who;
    int         addr;
    bit         last;
  } ev_t;

  ev_t        exp_q[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         b_lo = 0;
  int         b_hi = -1;
  logic [1:0] b_win = 2'b00;
  int         last_addr = 0;
  bit         mon_en = 1'b0;
  bit         ptr_m = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin : monitor
    ev_t e;
    if (mon_en && RST_N) begin
      check("busy", 64'(busy_o), 64'(cyc >= b_lo && cyc <= b_hi));
      check("gnt", 64'(gnt_o), (cyc >= b_lo && cyc < b_hi) ? 64'(b_win) : 64'd0);
      if (oe_o || done_o != 2'b00) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'({oe_o, done_o}), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", 64'(cyc), 64'(e.cyc));
          check("oe", 64'(oe_o), 64'(!e.is_done));
          check("done", 64'(done_o), e.is_done ? 64'(e.who) : 64'd0);
          if (e.is_done) begin
            check("add_wrap", 64'(add_o), 64'd0);
          end else begin
            check("add", 64'(add_o), 64'(e.addr));
            check("last", 64'(last_o), 64'(e.last));
            last_addr = e.addr;
          end
        end
      end else begin
        check("last_idle", 64'(last_o), 64'd0);
        check("add_hold", 64'(add_o), (cyc >= b_lo && cyc < b_hi) ? 64'(last_addr) : 64'd0);
      end
    end
  end

  // Serve every requester in r in round-robin order, predicting strobe times from hold history
  task automatic serve(input logic [1:0] r, input int hold_pct, input bit fixed_hold,
                       input bit early_drop);
    logic [1:0] pend;
    logic [1:0] oh;
    bit         win;
    bit         hp[256];
    int         s, g, t, d, drop_at;
    pend   = r;
    req_i  = r;
    hold_i = 1'b0;
    while (pend != 2'b00) begin
      s   = cyc;
      win = pend[ptr_m] ? ptr_m : ~ptr_m;
      oh  = win ? 2'b10 : 2'b01;
      g   = s + 1;
      foreach (hp[i]) hp[i] = fixed_hold ? (i == 1 || i == 2) : ($urandom_range(99) < hold_pct);
      t = g;
      exp_q.push_back('{g, 1'b0, oh, 0, NW == 1});
      for (int k = 1; k < NW; k++) begin
        t += PER;
        while (t - 1 - g < 256 && hp[t - 1 - g]) t++;
        exp_q.push_back('{t, 1'b0, oh, k, k == NW - 1});
      end
      d = t + 1;
      exp_q.push_back('{d, 1'b1, oh, 0, 1'b0});
      b_lo  = g;
      b_hi  = d;
      b_win = oh;
      ptr_m = ~win;
      drop_at = early_drop ? int'($urandom_range(d - 1, g)) : d;
      for (int c = g; c <= d; c++) begin
        next_cycle();
        hold_i = (c < d && c - g < 256) ? hp[c - g] : 1'($urandom_range(1));
        if (c >= drop_at) req_i[win] = 1'b0;
      end
      pend[win] = 1'b0;
      next_cycle();
      hold_i = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    req_i = 2'b00;
    repeat (n) begin
      next_cycle();
      hold_i = 1'($urandom_range(1));
    end
    hold_i = 1'b0;
  endtask

  // Start a burst for requester 0, then pull reset in the middle of its fourth cycle
  task automatic reset_mid();
    int g;
    req_i  = 2'b01;
    hold_i = 1'b0;
    g = cyc + 1;
    for (int k = 0; k < NW; k++) exp_q.push_back('{g + k * PER, 1'b0, 2'b01, k, k == NW - 1});
    exp_q.push_back('{g + (NW - 1) * PER + 1, 1'b1, 2'b01, 0, 1'b0});
    b_lo  = g;
    b_hi  = g + (NW - 1) * PER + 1;
    b_win = 2'b01;
    repeat (4) next_cycle();
    req_i = 2'b00;
    #2;
    mon_en = 1'b0;
    RST_N  = 1'b0;
    #1;
    check("rst_mid_gnt", 64'(gnt_o), 64'd0);
    check("rst_mid_add", 64'(add_o), 64'd0);
    check("rst_mid_oe", 64'(oe_o), 64'd0);
    check("rst_mid_last", 64'(last_o), 64'd0);
    check("rst_mid_done", 64'(done_o), 64'd0);
    check("rst_mid_busy", 64'(busy_o), 64'd0);
    exp_q.delete();
    b_lo  = 0;
    b_hi  = -1;
    ptr_m = 1'b0;
    repeat (2) next_cycle();
    RST_N  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic burst8();
    req2  = 2'b01;
    hold2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      req2 = 2'b00;
      check("w8_oe", 64'(oe2), 64'd1);
      check("w8_add", 64'(add2), 64'(k));
      check("w8_last", 64'(last2), 64'(k == 7));
      check("w8_gnt", 64'(gnt2), 64'd1);
    end
    next_cycle();
    check("w8_done", 64'(done2), 64'd1);
    check("w8_add_wrap", 64'(add2), 64'd0);
    check("w8_gnt_off", 64'(gnt2), 64'd0);
    check("w8_oe_off", 64'(oe2), 64'd0);
    next_cycle();
    check("w8_busy_off", 64'(busy2), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin : stim
    repeat (2) @(posedge CLK);
    #1;
    check("rst_gnt", 64'(gnt_o), 64'd0);
    check("rst_add", 64'(add_o), 64'd0);
    check("rst_oe", 64'(oe_o), 64'd0);
    check("rst_last", 64'(last_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_busy", 64'(busy_o), 64'd0);
    RST_N  = 1'b1;
    mon_en = 1'b1;
    next_cycle();
    serve(2'b01, 0, 1'b0, 1'b0);
    idle(2);
    serve(2'b11, 0, 1'b0, 1'b0);
    idle(1);
    serve(2'b01, 0, 1'b1, 1'b0);
    idle(1);
    serve(2'b10, 0, 1'b0, 1'b1);
    serve(2'b01, 0, 1'b0, 1'b0);
    idle(1);
    reset_mid();
    serve(2'b11, 0, 1'b0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      idle($urandom_range(3));
      serve(2'($urandom_range(3, 1)), 30, 1'b0, 1'($urandom_range(1)));
    end
    idle(4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    burst8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
